// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset vector and the buffered entry layout.
package inst_fetch_pkg;

   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned InstBus     = 32;

   localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [InstAddrBus-1:0] pc;
      logic [InstBus-1:0]     inst;
   } fetch_entry_t;

   function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
      return {addr[InstAddrBus-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Synchronous FIFO holding fetched {pc, inst} entries; flush empties it in one cycle.
module inst_buf #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   // A full buffer still accepts a push when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory requester feeding a small decode buffer.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned            BUF_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [InstAddrBus-1:0] redirect_pc_i,
   output logic                   mem_req_o,
   output logic [InstAddrBus-1:0] mem_addr_o,
   input  logic                   mem_gnt_i,
   input  logic                   mem_rvalid_i,
   input  logic [InstBus-1:0]     mem_rdata_i,
   output logic                   valid_o,
   output logic [InstAddrBus-1:0] pc_o,
   output logic [InstBus-1:0]     inst_o
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] LAST_SLOT = CW'(BUF_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                 state, state_n;
   logic [InstAddrBus-1:0] pc, pc_n;
   logic [InstAddrBus-1:0] req_pc, req_pc_n;
   logic                   kill, kill_n;
   logic                   granted;

   logic                   buf_push, buf_pop, buf_flush, buf_full, buf_empty;
   logic [CW-1:0]          buf_count;
   fetch_entry_t           push_entry, head;

   assign mem_req_o  = (state == REQ) && !kill;
   assign mem_addr_o = mem_req_o ? pc : '0;
   assign granted    = mem_req_o && mem_gnt_i;

   assign valid_o = !buf_empty;
   assign pc_o    = valid_o ? head.pc   : '0;
   assign inst_o  = valid_o ? head.inst : '0;
   assign buf_pop = valid_o && !stall_i;

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_pc_n   = req_pc;
      kill_n     = kill && !mem_rvalid_i;
      buf_push   = 1'b0;
      buf_flush  = 1'b0;
      push_entry = '{pc: req_pc, inst: mem_rdata_i};
      if (redirect_i) begin
         // Any response still owed by memory must be swallowed before refetching.
         buf_flush = 1'b1;
         pc_n      = word_align(redirect_pc_i);
         state_n   = REQ;
         kill_n    = (kill && !mem_rvalid_i) || ((state == WAIT) && !mem_rvalid_i) || granted;
      end else begin
         case (state)
            IDLE: if (!buf_full) state_n = REQ;
            REQ: begin
               if (granted) begin
                  req_pc_n = pc;
                  pc_n     = pc + 32'd4;
                  state_n  = WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid_i) begin
                  buf_push = 1'b1;
                  state_n  = (buf_pop || (buf_count < LAST_SLOT)) ? REQ : IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
         kill   <= ((state == WAIT) && !mem_rvalid_i) || granted;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         req_pc <= req_pc_n;
         kill   <= kill_n;
      end
   end

   inst_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (buf_flush),
      .push      (buf_push),
      .push_data (push_entry),
      .pop       (buf_pop),
      .pop_data  (head),
      .count     (buf_count),
      .full      (buf_full),
      .empty     (buf_empty)
   );

endmodule
